word_assembler: RTL and testbench

Downstream consumer of the three-phase byte sequencer. It latches an 8-bit byte on `en_high`, a second byte on `en_low`, and on the first cycle of `op_valid` pushes the assembled 16-bit word `{high, low}` into a small synchronous FIFO. The FIFO drains over a valid/ready handshake to the next stage. Protocol violations and FIFO overflow are reported as sticky flags.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/word_assembler_sync_fifo.sv | 85 ++++++++
 rtl/word_assembler.sv | 137 +++++++++++++
 tb/tb_word_assembler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the byte sequencer and the word assembler that consumes its output.
package seq_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_HI   = 2'd1,
        GOT_BOTH = 2'd2,
        HOLD     = 2'd3
    } asm_state_t;

    // Upstream three-phase sequencer states, kept here so both sides agree on encoding.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_HIGH = 2'd1,
        SEQ_LOW  = 2'd2,
        SEQ_OP   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/word_assembler_sync_fifo.sv
// Small synchronous FIFO with a registered head word, occupancy and full/empty flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        rdata_d = mem_d[rd_ptr_d];
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata = rdata_q;
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/word_assembler.sv
// Assembles {high, low} byte pairs from the sequencer into 16-bit words and queues them downstream.
module word_assembler #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned BYTE_W = seq_pkg::BYTE_W
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [BYTE_W-1:0]           din,
    input  logic                        en_high,
    input  logic                        en_low,
    input  logic                        op_valid,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [2*BYTE_W-1:0]         dout,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        overflow,
    output logic                        seq_err
);

    import seq_pkg::*;

    localparam int unsigned WORD_W = 2 * BYTE_W;

    asm_state_t        state_q, state_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic              overflow_q, overflow_d;
    logic              seq_err_q, seq_err_d;
    logic              push_req_c;
    logic              pop_c;
    logic              fifo_full;
    logic              fifo_empty;

    assign pop_c = !fifo_empty && out_ready;

    // Assembly FSM: op_valid is a level, so HOLD absorbs it until it drops.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        push_req_c = 1'b0;
        seq_err_d  = seq_err_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    seq_err_d = 1'b1;
                    state_d   = HOLD;
                end else if (en_high) begin
                    hi_d = din;
                    if (en_low) begin
                        lo_d    = din;
                        state_d = GOT_BOTH;
                    end else begin
                        state_d = GOT_HI;
                    end
                end else if (en_low) begin
                    seq_err_d = 1'b1;
                end
            end
            GOT_HI: begin
                if (op_valid) begin
                    seq_err_d = 1'b1;
                    state_d   = HOLD;
                end else begin
                    if (en_high) begin
                        hi_d = din;
                    end
                    if (en_low) begin
                        lo_d    = din;
                        state_d = GOT_BOTH;
                    end
                end
            end
            GOT_BOTH: begin
                if (op_valid) begin
                    push_req_c = 1'b1;
                    state_d    = HOLD;
                end else begin
                    if (en_high) begin
                        hi_d = din;
                    end
                    if (en_low) begin
                        lo_d = din;
                    end
                end
            end
            HOLD: begin
                if (!op_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push_req_c && fifo_full && !pop_c) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            overflow_q <= overflow_d;
            seq_err_q  <= seq_err_d;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push_req_c),
        .pop   (pop_c),
        .wdata ({hi_q, lo_q}),
        .rdata (dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_word_assembler.sv
// Directed and scoreboarded checks for word_assembler with the default DEPTH=4, BYTE_W=8.
module tb_word_assembler;

    localparam int unsigned DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  din = '0;
    logic        en_high = 1'b0;
    logic        en_low = 1'b0;
    logic        op_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] dout;
    logic [2:0]  count;
    logic        overflow;
    logic        seq_err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] mq [$];
    logic        exp_ovf = 1'b0;

    word_assembler #(.DEPTH(4), .BYTE_W(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .din       (din),
        .en_high   (en_high),
        .en_low    (en_low),
        .op_valid  (op_valid),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout      (dout),
        .count     (count),
        .overflow  (overflow),
        .seq_err   (seq_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [7:0] h, input logic [7:0] l, input int hold);
        en_high = 1'b1; din = h; tick();
        en_high = 1'b0; en_low = 1'b1; din = l; tick();
        en_low = 1'b0; op_valid = 1'b1;
        repeat (hold) tick();
        op_valid = 1'b0; tick();
    endtask

    task automatic pulse_reset();
        #2 RESET = 1'b0;
        #2 RESET = 1'b1;
    endtask

    // One clock with the queue model stepped alongside the DUT.
    task automatic mtick(input bit push_now, input logic [15:0] w);
        bit popping;
        popping = (mq.size() > 0) && out_ready;
        chk("rnd_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("rnd_dout", 32'(dout), 32'(mq[0]));
        tick();
        if (popping) void'(mq.pop_front());
        if (push_now) begin
            if (mq.size() < int'(DEPTH)) mq.push_back(w);
            else exp_ovf = 1'b1;
        end
        chk("rnd_count", 32'(count), 32'(mq.size()));
    endtask

    task automatic rnd_send(input logic [7:0] h, input logic [7:0] l, input int hold);
        out_ready = 1'($urandom_range(0, 1));
        en_high = 1'b1; din = h; mtick(1'b0, 16'h0);
        out_ready = 1'($urandom_range(0, 1));
        en_high = 1'b0; en_low = 1'b1; din = l; mtick(1'b0, 16'h0);
        en_low = 1'b0; op_valid = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        mtick(1'b1, {h, l});
        for (int k = 1; k < hold; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            mtick(1'b0, 16'h0);
        end
        op_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        mtick(1'b0, 16'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp2 [4];
        logic [15:0] exp3 [4];
        exp2 = '{16'h1020, 16'h1121, 16'h1222, 16'h1323};
        exp3 = '{16'hA1B1, 16'hA2B2, 16'hA3B3, 16'hC5D6};

        // Reset state
        #1 RESET = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_seqerr", 32'(seq_err), 32'h0);
        #4 RESET = 1'b1;
        tick();

        // Basic word 0xABCD, op_valid held 3 cycles
        out_ready = 1'b1;
        en_high = 1'b1; din = 8'hAB; tick();
        chk("t1_no_early_valid", 32'(out_valid), 32'h0);
        en_high = 1'b0; en_low = 1'b1; din = 8'hCD; tick();
        chk("t1_no_early_valid2", 32'(out_valid), 32'h0);
        en_low = 1'b0; op_valid = 1'b1; tick();
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_dout", 32'(dout), 32'hABCD);
        chk("t1_count_peak", 32'(count), 32'h1);
        tick();
        chk("t1_popped", 32'(count), 32'h0);
        tick();
        chk("t1_single_push", 32'(count), 32'h0);
        op_valid = 1'b0; tick();
        chk("t1_count_end", 32'(count), 32'h0);
        chk("t1_ovf", 32'(overflow), 32'h0);
        chk("t1_seqerr", 32'(seq_err), 32'h0);

        // Overflow: 5 words into a 4-deep FIFO, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_word(8'(8'h10 + i), 8'(8'h20 + i), 2);
        chk("t2_count_full", 32'(count), 32'h4);
        chk("t2_ovf", 32'(overflow), 32'h1);
        chk("t2_head", 32'(dout), 32'h1020);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_dout", 32'(dout), 32'(exp2[i]));
            chk("t2_drain_count", 32'(count), 32'(4 - i));
            tick();
        end
        chk("t2_empty", 32'(out_valid), 32'h0);
        chk("t2_count0", 32'(count), 32'h0);

        // Full FIFO with simultaneous push and pop
        pulse_reset();
        chk("t3_ovf_cleared", 32'(overflow), 32'h0);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(8'(8'hA0 + i), 8'(8'hB0 + i), 1);
        chk("t3_full", 32'(count), 32'h4);
        en_high = 1'b1; din = 8'hC5; tick();
        en_high = 1'b0; en_low = 1'b1; din = 8'hD6; tick();
        en_low = 1'b0; op_valid = 1'b1; out_ready = 1'b1; tick();
        chk("t3_count_kept", 32'(count), 32'h4);
        chk("t3_no_ovf", 32'(overflow), 32'h0);
        chk("t3_head_adv", 32'(dout), 32'hA1B1);
        out_ready = 1'b0; op_valid = 1'b0; tick();
        chk("t3_count_hold", 32'(count), 32'h4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_dout", 32'(dout), 32'(exp3[i]));
            tick();
        end
        chk("t3_count0", 32'(count), 32'h0);

        // op_valid after only the high byte
        en_high = 1'b1; din = 8'h55; tick();
        en_high = 1'b0; op_valid = 1'b1; tick();
        chk("t4_seqerr", 32'(seq_err), 32'h1);
        chk("t4_count", 32'(count), 32'h0);
        chk("t4_valid", 32'(out_valid), 32'h0);
        tick();
        op_valid = 1'b0; tick();
        out_ready = 1'b0;
        send_word(8'h12, 8'h34, 1);
        chk("t4_recover_count", 32'(count), 32'h1);
        chk("t4_recover_dout", 32'(dout), 32'h1234);
        chk("t4_seqerr_sticky", 32'(seq_err), 32'h1);

        // Reset mid-sequence with two words queued
        send_word(8'h56, 8'h78, 1);
        chk("t5_two_queued", 32'(count), 32'h2);
        en_high = 1'b1; din = 8'h9A; tick();
        en_high = 1'b0;
        #3 RESET = 1'b0;
        #1;
        chk("t5_rst_count", 32'(count), 32'h0);
        chk("t5_rst_valid", 32'(out_valid), 32'h0);
        chk("t5_rst_dout", 32'(dout), 32'h0);
        chk("t5_rst_seqerr", 32'(seq_err), 32'h0);
        chk("t5_rst_ovf", 32'(overflow), 32'h0);
        #4 RESET = 1'b1;
        tick();
        send_word(8'hBE, 8'hEF, 1);
        chk("t5_one_word", 32'(count), 32'h1);
        chk("t5_dout", 32'(dout), 32'hBEEF);
        chk("t5_no_seqerr", 32'(seq_err), 32'h0);
        out_ready = 1'b1; tick();
        chk("t5_drained", 32'(count), 32'h0);
        pulse_reset();
        tick();
        op_valid = 1'b1; tick();
        chk("t5_stale_seqerr", 32'(seq_err), 32'h1);
        chk("t5_stale_nopush", 32'(count), 32'h0);
        op_valid = 1'b0; tick();

        // Random backpressure against a queue model
        pulse_reset();
        tick();
        mq.delete();
        exp_ovf = 1'b0;
        for (int s = 0; s < 100; s++) begin
            rnd_send(8'($urandom), 8'($urandom), int'($urandom_range(1, 3)));
        end
        out_ready = 1'b1;
        for (int d = 0; d < 8; d++) mtick(1'b0, 16'h0);
        chk("t6_empty", 32'(out_valid), 32'h0);
        chk("t6_ovf", 32'(overflow), 32'(exp_ovf));
        chk("t6_seqerr", 32'(seq_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
